// File: rtl/out_display_seq.sv
// ---------------------------------------------------------------------------
// out_display_seq
//
// Sequential OUT display stage. It takes the low VAL_BITS bits of the
// datapath value as a two's-complement number and converts its magnitude to
// BCD with a bit-serial double-dabble, one bit per clock. It then drives
// one sign display and DIGITS digit displays from registers.
//
// Operation
//   - A conversion starts when start_i is sampled high in IDLE with
//     flag_out_i high.
//   - The displays and done_o are updated VAL_BITS+1 clocks after the start
//     edge.
//   - Magnitudes above 10^DIGITS-1 show "E" on every digit and set
//     overflow_o.
//   - flag_out_i low at any edge blanks every display and aborts a
//     conversion that is in progress.
//
// Optional build macro
//   OUT_LZ_BLANK_EN : blank leading zero digits (the ones digit always shows).
//
// Parameters
//   BITS     : width of value_i
//   VAL_BITS : low bits of value_i used as the signed number (2..BITS)
//   DIGITS   : number of decimal digit displays, digit 0 = ones
//
// Ports
//   clock_i      : system clock, rising edge
//   reset_n_i    : asynchronous active-low reset
//   flag_out_i   : display enable (OUT instruction executed)
//   start_i      : single-cycle conversion request
//   value_i      : operand, only value_i[VAL_BITS-1:0] is used
//   busy_o       : conversion in progress (CONV or LATCH)
//   done_o       : one-cycle pulse, displays updated this cycle
//   overflow_o   : last converted magnitude exceeded 10^DIGITS-1
//   out_sign_o   : sign display segments, active-low, bit0=a .. bit6=g
//   out_digits_o : digit segments, digit i at [7i+6:7i]
// ---------------------------------------------------------------------------
module out_display_seq #(
  parameter int BITS     = 32,
  parameter int VAL_BITS = 10,
  parameter int DIGITS   = 3
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  flag_out_i,
  input  logic                  start_i,
  input  logic [BITS-1:0]       value_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [6:0]            out_sign_o,
  output logic [DIGITS*7-1:0]   out_digits_o
);

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CONV  = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

  // Segment constants (active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  localparam int          CW      = $clog2(VAL_BITS + 1);
  localparam int          BCD_W   = DIGITS * 4;
  localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS - 1);

  // BCD nibble to segment pattern; non-decimal nibbles show blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  logic [1:0]          state_q,       state_d;
  logic                sign_q,        sign_d;
  logic                ovf_q,         ovf_d;
  logic [VAL_BITS-1:0] mag_q,         mag_d;
  logic [BCD_W-1:0]    bcd_q,         bcd_d;
  logic [CW-1:0]       cnt_q,         cnt_d;
  logic                done_q,        done_d;
  logic                overflow_q,    overflow_d;
  logic [6:0]          sign_disp_q,   sign_disp_d;
  logic [DIGITS*7-1:0] digits_disp_q, digits_disp_d;

  // -------------------------------------------------------------------------
  // Operand capture: absolute value in VAL_BITS unsigned bits, so the most
  // negative input (-2^(VAL_BITS-1)) yields the correct magnitude 2^(VAL_BITS-1).
  // -------------------------------------------------------------------------
  logic [VAL_BITS-1:0] val_w;
  logic [VAL_BITS-1:0] mag_w;
  logic                ovf_w;

  assign val_w = value_i[VAL_BITS-1:0];
  assign mag_w = val_w[VAL_BITS-1] ? (~val_w + VAL_BITS'(1)) : val_w;
  assign ovf_w = 64'(mag_w) > MAX_VAL;

  generate
    if (BITS > VAL_BITS) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^value_i[BITS-1:VAL_BITS];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Double-dabble adjust: every nibble >= 5 gets +3 before the shift so that
  // the following doubling carries correctly into the next decimal digit.
  // -------------------------------------------------------------------------
  logic [BCD_W-1:0] bcd_adj;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5)
                                  ? bcd_q[4*gi +: 4] + 4'd3
                                  : bcd_q[4*gi +: 4];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Display patterns presented at LATCH
  // -------------------------------------------------------------------------
  logic [DIGITS*7-1:0] lat_digits;
  logic [6:0]          lat_sign;

  always_comb begin
`ifdef OUT_LZ_BLANK_EN
    logic seen_nz;
    seen_nz = 1'b0;
`endif
    lat_digits = '0;
    // Scanned from the top digit down so the leading-zero state is known
    // by the time each lower digit is decided.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (ovf_q) begin
        lat_digits[7*i +: 7] = SEG_E;
      end else begin
`ifdef OUT_LZ_BLANK_EN
        if (bcd_q[4*i +: 4] != 4'd0) begin
          seen_nz = 1'b1;
        end
        if (seen_nz || (i == 0)) begin
          lat_digits[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
        end else begin
          lat_digits[7*i +: 7] = SEG_BLANK;
        end
`else
        lat_digits[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
`endif
      end
    end
  end

  // A zero magnitude can never carry a sign; guard it explicitly anyway.
  assign lat_sign = (!ovf_q && sign_q && (bcd_q != '0)) ? SEG_MINUS : SEG_BLANK;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    sign_d        = sign_q;
    ovf_d         = ovf_q;
    mag_d         = mag_q;
    bcd_d         = bcd_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    overflow_d    = overflow_q;
    sign_disp_d   = sign_disp_q;
    digits_disp_d = digits_disp_q;

    if (!flag_out_i) begin
      // Display disabled: blank everything and abandon any conversion.
      // overflow_q intentionally keeps the last result.
      state_d       = S_IDLE;
      sign_disp_d   = SEG_BLANK;
      digits_disp_d = {DIGITS{SEG_BLANK}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            sign_d  = val_w[VAL_BITS-1];
            mag_d   = mag_w;
            ovf_d   = ovf_w;
            bcd_d   = '0;
            cnt_d   = CW'(VAL_BITS);
            state_d = S_CONV;
          end
        end

        S_CONV: begin
          // Bits leaving the top nibble are dropped; ovf_q already records
          // every case where that can happen.
          bcd_d = {bcd_adj[BCD_W-2:0], mag_q[VAL_BITS-1]};
          mag_d = {mag_q[VAL_BITS-2:0], 1'b0};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_LATCH;
          end
        end

        S_LATCH: begin
          sign_disp_d   = lat_sign;
          digits_disp_d = lat_digits;
          overflow_d    = ovf_q;
          done_d        = 1'b1;
          state_d       = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= S_IDLE;
      sign_q        <= 1'b0;
      ovf_q         <= 1'b0;
      mag_q         <= '0;
      bcd_q         <= '0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      sign_disp_q   <= SEG_BLANK;
      digits_disp_q <= {DIGITS{SEG_BLANK}};
    end else begin
      state_q       <= state_d;
      sign_q        <= sign_d;
      ovf_q         <= ovf_d;
      mag_q         <= mag_d;
      bcd_q         <= bcd_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      sign_disp_q   <= sign_disp_d;
      digits_disp_q <= digits_disp_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign overflow_o   = overflow_q;
  assign out_sign_o   = sign_disp_q;
  assign out_digits_o = digits_disp_q;

endmodule

// File: tb/tb_out_display_seq.sv
// ---------------------------------------------------------------------------
// tb_out_display_seq
//
// Bench for out_display_seq. It drives two instances: one with DIGITS=3 (A)
// and one with DIGITS=2 (B). Expected displays are derived arithmetically
// from the signed value (divide/modulo by powers of ten). Honours
// OUT_LZ_BLANK_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_out_display_seq;

  localparam int BITS = 32;
  localparam int VB   = 10;

  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] SEGE  = 7'b0000110;

  logic        clk;
  logic        rst_n;

  logic        flag_a, start_a, busy_a, done_a, ovf_a;
  logic [31:0] value_a;
  logic [6:0]  sign_a;
  logic [20:0] dig_a;

  logic        flag_b, start_b, busy_b, done_b, ovf_b;
  logic [31:0] value_b;
  logic [6:0]  sign_b;
  logic [13:0] dig_b;

  int checks = 0;
  int errors = 0;

  out_display_seq #(.BITS(BITS), .VAL_BITS(VB), .DIGITS(3)) u_dut_a (
    .clock_i      (clk),
    .reset_n_i    (rst_n),
    .flag_out_i   (flag_a),
    .start_i      (start_a),
    .value_i      (value_a),
    .busy_o       (busy_a),
    .done_o       (done_a),
    .overflow_o   (ovf_a),
    .out_sign_o   (sign_a),
    .out_digits_o (dig_a)
  );

  out_display_seq #(.BITS(BITS), .VAL_BITS(VB), .DIGITS(2)) u_dut_b (
    .clock_i      (clk),
    .reset_n_i    (rst_n),
    .flag_out_i   (flag_b),
    .start_i      (start_b),
    .value_i      (value_b),
    .busy_o       (busy_b),
    .done_o       (done_b),
    .overflow_o   (ovf_b),
    .out_sign_o   (sign_b),
    .out_digits_o (dig_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Standard decimal segment table
  function automatic logic [6:0] seg_of(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  // Reference: what a D-digit display should show for value v
  function automatic void model(input logic [31:0] v, input int d,
                                output logic [6:0] s, output logic [20:0] digs,
                                output logic ov);
    int sv, mag, maxv, p;
    bit lz;
`ifdef OUT_LZ_BLANK_EN
    lz = 1'b1;
`else
    lz = 1'b0;
`endif
    sv = int'({22'b0, v[VB-1:0]});
    if (v[VB-1]) sv = sv - (1 << VB);
    mag = (sv < 0) ? -sv : sv;
    maxv = 1;
    for (int i = 0; i < d; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    ov = (mag > maxv);
    digs = '1;
    p = 1;
    for (int i = 0; i < d; i++) begin
      if (ov)                          digs[7*i +: 7] = SEGE;
      else if (lz && i > 0 && mag < p) digs[7*i +: 7] = BLANK;
      else                             digs[7*i +: 7] = seg_of((mag / p) % 10);
      p = p * 10;
    end
    s = (!ov && sv < 0) ? MINUS : BLANK;
  endfunction

  // One full conversion on instance A (use_b=0) or B (use_b=1)
  task automatic run_conv(input bit use_b, input logic [31:0] v, input string tag);
    logic [6:0]  es;
    logic [20:0] ed;
    logic        eo;
    int          n;
    bit          got;
    model(v, use_b ? 2 : 3, es, ed, eo);
    if (use_b) begin value_b = v; start_b = 1'b1; end
    else       begin value_a = v; start_a = 1'b1; end
    tick();                               // edge k
    start_a = 1'b0;
    start_b = 1'b0;
    check($sformatf("%s.busy v=%0h", tag, v), 64'(use_b ? busy_b : busy_a), 64'd1);
    got = 1'b0;
    n   = 0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (use_b ? done_b : done_a) got = 1'b1;
    end
    check($sformatf("%s.latency v=%0h", tag, v), 64'(n), 64'(VB + 1));
    if (use_b) begin
      check($sformatf("%s.digits v=%0h", tag, v), 64'(dig_b), 64'(ed[13:0]));
      check($sformatf("%s.sign v=%0h", tag, v), 64'(sign_b), 64'(es));
      check($sformatf("%s.ovf v=%0h", tag, v), 64'(ovf_b), 64'(eo));
      check($sformatf("%s.idle v=%0h", tag, v), 64'(busy_b), 64'd0);
    end else begin
      check($sformatf("%s.digits v=%0h", tag, v), 64'(dig_a), 64'(ed));
      check($sformatf("%s.sign v=%0h", tag, v), 64'(sign_a), 64'(es));
      check($sformatf("%s.ovf v=%0h", tag, v), 64'(ovf_a), 64'(eo));
      check($sformatf("%s.idle v=%0h", tag, v), 64'(busy_a), 64'd0);
    end
    $display("conv %s value=%0h exp_sign=%0h exp_digits=%0h exp_ovf=%0d latency=%0d",
             tag, v[VB-1:0], es, ed, eo, n);
    tick();
    check($sformatf("%s.done_pulse v=%0h", tag, v), 64'(use_b ? done_b : done_a), 64'd0);
  endtask

  initial begin
    logic [6:0]  es;
    logic [20:0] ed;
    logic        eo;
    logic [31:0] rv;

    // ---------------- reset with flag_out and start asserted --------------
    rst_n   = 1'b0;
    flag_a  = 1'b1; start_a = 1'b1; value_a = 32'd123;
    flag_b  = 1'b1; start_b = 1'b1; value_b = 32'd99;
    #22;
    check("rst.sign_a",  64'(sign_a), 64'(BLANK));
    check("rst.dig_a",   64'(dig_a),  64'({3{BLANK}}));
    check("rst.busy_a",  64'(busy_a), 64'd0);
    check("rst.done_a",  64'(done_a), 64'd0);
    check("rst.ovf_a",   64'(ovf_a),  64'd0);
    check("rst.sign_b",  64'(sign_b), 64'(BLANK));
    check("rst.dig_b",   64'(dig_b),  64'({2{BLANK}}));
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("post_rst.dig_a",  64'(dig_a),  64'({3{BLANK}}));
    check("post_rst.busy_a", 64'(busy_a), 64'd0);
    $display("reset checks done");

    // ---------------- directed conversions on DIGITS=3 ---------------------
    run_conv(1'b0, 32'd123, "A123");
    // displays hold while idle
    model(32'd123, 3, es, ed, eo);
    tick(); tick(); tick();
    check("hold.dig_a",  64'(dig_a),  64'(ed));
    check("hold.sign_a", 64'(sign_a), 64'(es));
    run_conv(1'b0, 32'h0000_03FB, "Aneg5");
    run_conv(1'b0, 32'h0000_0200, "Amin");
    run_conv(1'b0, 32'd0,         "Azero");
    run_conv(1'b0, 32'd511,       "Amax");
    run_conv(1'b0, 32'hFFFF_FC0A, "Ahigh");   // upper bits ignored
    run_conv(1'b0, 32'd7,         "Asmall");

    // ---------------- extra start ignored, flag_out drop aborts ------------
    value_a = 32'd456;
    start_a = 1'b1;
    tick();                                   // edge k
    start_a = 1'b0;
    tick(); tick();                           // k+2
    start_a = 1'b1; value_a = 32'd789;
    tick();                                   // k+3: ignored
    start_a = 1'b0;
    check("abort.busy_k3", 64'(busy_a), 64'd1);
    tick();                                   // k+4
    flag_a = 1'b0;
    tick();                                   // k+5
    check("abort.sign",  64'(sign_a), 64'(BLANK));
    check("abort.dig",   64'(dig_a),  64'({3{BLANK}}));
    check("abort.busy",  64'(busy_a), 64'd0);
    check("abort.done5", 64'(done_a), 64'd0);
    flag_a = 1'b1;
    for (int i = 6; i <= 15; i++) begin
      tick();
      check($sformatf("abort.nodone k+%0d", i), 64'(done_a), 64'd0);
    end
    check("abort.dig_blank_held", 64'(dig_a), 64'({3{BLANK}}));
    $display("abort sequence done");

    // start with flag_out low is ignored
    flag_a = 1'b0; start_a = 1'b1; value_a = 32'd42;
    tick();
    start_a = 1'b0; flag_a = 1'b1;
    check("noflag.busy", 64'(busy_a), 64'd0);
    $display("start with flag low done");

    // ---------------- mid-conversion asynchronous reset --------------------
    value_a = 32'd321; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst.busy", 64'(busy_a), 64'd0);
    check("midrst.dig",  64'(dig_a),  64'({3{BLANK}}));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("mid-conversion reset done");

    // ---------------- random conversions on DIGITS=3 -----------------------
    for (int i = 0; i < 25; i++) begin
      rv = $urandom;
      run_conv(1'b0, rv, $sformatf("Arnd%0d", i));
      if ($urandom_range(0, 2) == 0) tick();
    end

    // ---------------- DIGITS=2 instance ------------------------------------
    run_conv(1'b1, 32'd100, "B100");
    // overflow survives a flag_out drop, displays blank
    flag_b = 1'b0;
    tick();
    check("B.flagdrop.ovf",  64'(ovf_b),  64'd1);
    check("B.flagdrop.dig",  64'(dig_b),  64'({2{BLANK}}));
    check("B.flagdrop.sign", 64'(sign_b), 64'(BLANK));
    flag_b = 1'b1;
    tick();
    run_conv(1'b1, 32'd99,        "B99");
    run_conv(1'b1, 32'h0000_039D, "Bneg99");
    run_conv(1'b1, 32'h0000_039C, "Bneg100");
    run_conv(1'b1, 32'd3,         "B3");
    for (int i = 0; i < 15; i++) begin
      rv = $urandom;
      run_conv(1'b1, rv, $sformatf("Brnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_display_seq.md
Name: out_display_seq

Overview:
- Sequential, parametrised successor to the processor's combinational OUT display stage.
- Converts a two's-complement field of the output-instruction value to sign-magnitude BCD using an iterative double-dabble, one bit per clock.
- Drives one sign 7-segment display and DIGITS digit displays from registered outputs.
- Uses a start/busy/done handshake, flags out-of-range values, and blanks all displays when the output flag is low.

Parameters:
BITS, 32, width of the value bus from the datapath
VAL_BITS, 10, low bits of value interpreted as a signed number; VAL_BITS <= BITS, VAL_BITS >= 2
DIGITS, 3, number of decimal digit displays (ones first)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
flag_out  input  1  display enable (OUT instruction executed)
start  input  1  single-cycle conversion request
value  input  BITS  operand; only value[VAL_BITS-1:0] is used
busy  output  1  conversion in progress
done  output  1  one-cycle pulse, displays updated this cycle
overflow  output  1  last converted magnitude exceeded 10^DIGITS-1
out_sign  output  7  sign display segments
out_digits  output  DIGITS*7  digit segments; digit i at bits [7i+6:7i], digit 0 = ones

Behaviour:
- Segment code: bit0=a … bit6=g, active-low (0 = lit). Fixed codes:
  - Blank = 7'h7F
  - Minus = 7'b0111111
  - E = 7'b0000110
  - Digits 0-9 use the standard patterns, e.g. 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 5=7'b0010010.
- Reset (reset_n=0, asynchronous): state IDLE; busy=0, done=0, overflow=0; all displays Blank.
- States: IDLE, CONV, LATCH.
- IDLE:
  - If start=1 and flag_out=1 at a rising edge, capture sign = value[VAL_BITS-1].
  - Capture magnitude = two's-complement absolute value, VAL_BITS wide unsigned, so that -2^(VAL_BITS-1) is correct.
  - Capture ovf = (magnitude > 10^DIGITS-1).
  - Clear the BCD register (DIGITS*4 bits), load the shift counter with VAL_BITS, go to CONV.
- CONV:
  - Each cycle: add 3 to every BCD nibble >= 5, then shift {bcd, mag} left by one and decrement the counter.
  - After VAL_BITS cycles, go to LATCH. Bits shifted out of the top BCD nibble are discarded; ovf covers that case.
- LATCH (one cycle): load the display registers, set done=1, set overflow=ovf, return to IDLE.
  - ovf=1: every digit shows E, sign shows Blank.
  - ovf=0: digits show BCD; sign shows Minus if negative, Blank otherwise.
  - Magnitude zero is never negative.
- busy=1 in CONV and LATCH.
- Latency: start sampled at edge k; outputs and done valid after edge k+VAL_BITS+1.
- start while busy is ignored, with no queueing.
- start with flag_out=0 is ignored.
- flag_out=0 at any edge, in any state:
  - All displays go Blank at that edge, state goes to IDLE, busy=0, no done pulse.
  - overflow keeps its value.
- Display registers hold between conversions, until flag_out drops or a new conversion latches.
- Mid-operation reset: behaves as the reset state immediately.

Optional Feature:
- Macro OUT_LZ_BLANK_EN enables leading-zero suppression.
- Defined: at LATCH (ovf=0), every digit above the most significant nonzero digit is Blank. The ones digit always shows (value 0 -> "0"). Sign placement is unchanged (sign display only).
- Undefined: all DIGITS digits shown, including leading zeros.
- Overflow display is identical either way.

Test Plan:
- Reset asserted with flag_out=1 and start=1 -> all 4 displays 7'h7F, busy=0, done=0, overflow=0; stays so until the first start.
- value=123, flag_out=1, start pulse at edge k:
  - busy=1 from edge k+1.
  - done=1 only after edge k+11.
  - out_digits = {1,2,3} = {7'b1111001, 7'b0100100, 7'b0110000}.
  - out_sign = Blank, overflow=0.
- value[9:0]=10'h3FB (-5):
  - Macro off: digits {0,0,5}.
  - Macro on: digits {Blank,Blank,5}.
  - out_sign = 7'b0111111 in both cases.
  - value[9:0]=10'h200 -> digits {5,1,2}, sign Minus.
- start at k, extra start at k+3, flag_out dropped at k+5:
  - Extra start ignored.
  - At edge k+5 all displays Blank, busy=0.
  - No done pulse through k+15.
- DIGITS=2 override, value=100 -> done after VAL_BITS+1 cycles, overflow=1, both digits 7'b0000110, sign Blank.
- DIGITS=2 override, then value=99 -> overflow=0, digits {9,9}.
